// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared encodings, FSM state type and button bit positions for btn_arbiter
package btn_pkg;

    localparam logic [1:0] OWN_NONE  = 2'b00;
    localparam logic [1:0] OWN_WIRED = 2'b01;
    localparam logic [1:0] OWN_WLESS = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WIRED,
        S_WLESS
    } state_t;

    localparam int B_W   = 0;
    localparam int B_S   = 1;
    localparam int B_A   = 2;
    localparam int B_D   = 3;
    localparam int B_ST  = 4;
    localparam int B_TRI = 5;
    localparam int B_SQR = 6;
    localparam int B_CIR = 7;
    localparam int B_CRO = 8;

    function automatic logic [1:0] own_code(input state_t st);
        case (st)
            S_WIRED: return OWN_WIRED;
            S_WLESS: return OWN_WLESS;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - single-channel debouncer; db follows raw after DB_CYCLES stable cycles
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [CW-1:0] cnt;

    // Count clears on reaching the limit, so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (raw == db) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            db  <= raw;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/btn_arbiter.sv
// rtl/btn_arbiter.sv - debounces wired/wireless buttons and grants control to one source at a time
module btn_arbiter
    import btn_pkg::*;
#(
    parameter int DB_CYCLES   = 500000,
    parameter int IDLE_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] wired_btn,
    input  logic [8:0] wless_btn,
    input  logic       sw_mode,
    input  logic       sw_ret,
    output logic [3:0] dir_out,
    output logic       st_pulse,
    output logic [1:0] owner,
    output logic       mode_sel,
    output logic       stop_pulse,
    output logic       return_pulse
);

    localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

    logic [15:0] raw;
    logic [15:0] db;
    assign raw = {sw_ret, sw_mode, wless_btn, wired_btn};

    for (genvar i = 0; i < 16; i++) begin : g_db
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw[i]),
            .db    (db[i])
        );
    end

    logic [4:0] wired_db;
    logic [8:0] wless_db;
    logic       mode_db;
    logic       ret_db;
    logic       unused_tri;
    assign wired_db   = db[4:0];
    assign wless_db   = db[13:5];
    assign mode_db    = db[14];
    assign ret_db     = db[15];
    assign unused_tri = wless_db[B_TRI];

    logic wired_act, wless_act;
    assign wired_act = |wired_db[B_ST:B_W];
    assign wless_act = |wless_db[B_ST:B_W];

    state_t        state, next_state;
    logic [IW-1:0] idle_cnt;
    logic          owner_act;
    logic          wired_st_q, wless_st_q, sqr_q, ret_q;
    logic [3:0]    sel_dir;
    logic          sel_st;
    logic          ret_lvl;

    assign ret_lvl = wless_db[B_CIR] | ret_db;

    always_comb begin
        next_state = state;
        owner_act  = 1'b0;
        case (state)
            S_IDLE: begin
                if (wired_act)      next_state = S_WIRED;
                else if (wless_act) next_state = S_WLESS;
            end
            S_WIRED: begin
                owner_act = wired_act;
                if (!wired_act && idle_cnt == IW'(IDLE_CYCLES - 1)) next_state = S_IDLE;
            end
            S_WLESS: begin
                owner_act = wless_act;
                if (!wless_act && idle_cnt == IW'(IDLE_CYCLES - 1)) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs follow the next-state owner so a grant forwards its own press.
    always_comb begin
        sel_dir = 4'b0000;
        sel_st  = 1'b0;
        case (next_state)
            S_WIRED: begin
                sel_dir = wired_db[B_D:B_W];
                sel_st  = wired_db[B_ST] & ~wired_st_q;
            end
            S_WLESS: begin
                sel_dir = wless_db[B_D:B_W];
                sel_st  = wless_db[B_ST] & ~wless_st_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idle_cnt     <= '0;
            wired_st_q   <= 1'b0;
            wless_st_q   <= 1'b0;
            sqr_q        <= 1'b0;
            ret_q        <= 1'b0;
            dir_out      <= 4'b0000;
            st_pulse     <= 1'b0;
            owner        <= OWN_NONE;
            mode_sel     <= 1'b1;
            stop_pulse   <= 1'b0;
            return_pulse <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state || state == S_IDLE || owner_act)
                idle_cnt <= '0;
            else if (idle_cnt != IW'(IDLE_CYCLES - 1))
                idle_cnt <= idle_cnt + 1'b1;
            wired_st_q   <= wired_db[B_ST];
            wless_st_q   <= wless_db[B_ST];
            sqr_q        <= wless_db[B_SQR];
            ret_q        <= ret_lvl;
            dir_out      <= sel_dir;
            st_pulse     <= sel_st;
            owner        <= own_code(next_state);
            mode_sel     <= ~(mode_db | wless_db[B_CRO]);
            stop_pulse   <= wless_db[B_SQR] & ~sqr_q;
            return_pulse <= ret_lvl & ~ret_q;
        end
    end

endmodule

// File: tb/tb_btn_arbiter.sv
// tb/tb_btn_arbiter.sv - scoreboard bench for btn_arbiter with DB_CYCLES=4, IDLE_CYCLES=16
module tb_btn_arbiter;

    localparam int DB   = 4;
    localparam int IDLE = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] wired_btn = '0;
    logic [8:0] wless_btn = '0;
    logic       sw_mode = 1'b0;
    logic       sw_ret = 1'b0;
    logic [3:0] dir_out;
    logic       st_pulse;
    logic [1:0] owner;
    logic       mode_sel;
    logic       stop_pulse;
    logic       return_pulse;

    btn_arbiter #(.DB_CYCLES(DB), .IDLE_CYCLES(IDLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wired_btn    (wired_btn),
        .wless_btn    (wless_btn),
        .sw_mode      (sw_mode),
        .sw_ret       (sw_ret),
        .dir_out      (dir_out),
        .st_pulse     (st_pulse),
        .owner        (owner),
        .mode_sel     (mode_sel),
        .stop_pulse   (stop_pulse),
        .return_pulse (return_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        string      tag;
        int         at;
        logic [9:0] val;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int n_st = 0, n_stop = 0, n_ret = 0;
    int n, m, s, p, base;
    logic [9:0] obs;

    // Output vector: {return, stop, mode, owner[1:0], st, dir[3:0]}
    localparam logic [9:0] V_IDLE = 10'b0010000000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [9:0] ov(input bit ret, input bit stp, input bit mode,
                                      input logic [1:0] own, input bit st, input logic [3:0] dir);
        return {ret, stp, mode, own, st, dir};
    endfunction

    task automatic expect_at(input string tag, input int at, input logic [9:0] v);
        q.push_back('{tag, at, v});
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        obs = {return_pulse, stop_pulse, mode_sel, owner, st_pulse, dir_out};
        n_st   = n_st + int'(st_pulse);
        n_stop = n_stop + int'(stop_pulse);
        n_ret  = n_ret + int'(return_pulse);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at <= cyc) begin
                if (q[i].at < cyc) check_eq({q[i].tag, "_late"}, cyc, q[i].at);
                else               check_eq(q[i].tag, {22'd0, obs}, {22'd0, q[i].val});
                q.delete(i);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        step(3);
        expect_at("reset", cyc, V_IDLE);
        step(1);
        rst_n = 1'b1;
        step(2);

        // bounce on wired w
        wired_btn[0] = 1'b1; step(1);
        wired_btn[0] = 1'b0; step(1);
        wired_btn[0] = 1'b1;
        base = cyc;
        for (int k = 1; k <= 4; k++) expect_at("bounce_early", base + k, V_IDLE);
        expect_at("bounce_grant", base + 5, ov(0, 0, 1, 2'b01, 0, 4'b0001));
        step(8);
        wired_btn[0] = 1'b0;
        m = cyc;
        expect_at("release_dir", m + 5, ov(0, 0, 1, 2'b01, 0, 4'b0000));
        expect_at("idle_hold", m + 19, ov(0, 0, 1, 2'b01, 0, 4'b0000));
        expect_at("idle_drop", m + 20, V_IDLE);
        step(25);

        // tie: wired a vs wireless d
        n = cyc;
        wired_btn[2] = 1'b1;
        wless_btn[3] = 1'b1;
        expect_at("tie_early", n + 4, V_IDLE);
        for (int k = 5; k <= 10; k++) expect_at("tie_wired", n + k, ov(0, 0, 1, 2'b01, 0, 4'b0100));
        step(10);
        wired_btn[2] = 1'b0;
        wless_btn[3] = 1'b0;
        m = cyc;
        expect_at("tie_release", m + 5, ov(0, 0, 1, 2'b01, 0, 4'b0000));
        expect_at("tie_drop", m + 20, V_IDLE);
        step(25);

        // handover from wired to held wireless s
        n = cyc;
        wired_btn[0] = 1'b1;
        wless_btn[1] = 1'b1;
        expect_at("ho_grant", n + 5, ov(0, 0, 1, 2'b01, 0, 4'b0001));
        step(8);
        wired_btn[0] = 1'b0;
        m = cyc;
        expect_at("ho_hold_dir", m + 4, ov(0, 0, 1, 2'b01, 0, 4'b0001));
        expect_at("ho_rel", m + 5, ov(0, 0, 1, 2'b01, 0, 4'b0000));
        expect_at("ho_last", m + 19, ov(0, 0, 1, 2'b01, 0, 4'b0000));
        expect_at("ho_drop", m + 20, V_IDLE);
        expect_at("ho_wless", m + 21, ov(0, 0, 1, 2'b10, 0, 4'b0010));
        expect_at("ho_wless2", m + 22, ov(0, 0, 1, 2'b10, 0, 4'b0010));
        step(24);
        wless_btn[1] = 1'b0;
        p = cyc;
        expect_at("wl_rel", p + 5, ov(0, 0, 1, 2'b10, 0, 4'b0000));
        expect_at("wl_drop", p + 20, V_IDLE);
        step(25);

        // single st pulse, single stop pulse
        n_st = 0;
        n_stop = 0;
        n = cyc;
        wired_btn[4] = 1'b1;
        expect_at("st_pulse", n + 5, ov(0, 0, 1, 2'b01, 1, 4'b0000));
        expect_at("st_once", n + 6, ov(0, 0, 1, 2'b01, 0, 4'b0000));
        step(10);
        wless_btn[6] = 1'b1;
        s = cyc;
        expect_at("stop_pulse", s + 5, ov(0, 1, 1, 2'b01, 0, 4'b0000));
        expect_at("stop_once", s + 6, ov(0, 0, 1, 2'b01, 0, 4'b0000));
        step(40);
        wless_btn[6] = 1'b0;
        wired_btn[4] = 1'b0;
        step(30);
        check_eq("st_count", n_st, 1);
        check_eq("stop_count", n_stop, 1);

        // merged return: cir and sw_ret overlap
        n_ret = 0;
        n = cyc;
        wless_btn[7] = 1'b1;
        expect_at("ret_pulse", n + 5, ov(1, 0, 1, 2'b00, 0, 4'b0000));
        expect_at("ret_once", n + 6, V_IDLE);
        step(3);
        sw_ret = 1'b1;
        step(3);
        wless_btn[7] = 1'b0;
        step(4);
        sw_ret = 1'b0;
        step(15);
        check_eq("ret_count", n_ret, 1);

        // mode via cro, then via sw_mode
        n = cyc;
        wless_btn[8] = 1'b1;
        expect_at("cro_early", n + 4, V_IDLE);
        expect_at("cro_mode0", n + 5, ov(0, 0, 0, 2'b00, 0, 4'b0000));
        step(10);
        wless_btn[8] = 1'b0;
        m = cyc;
        expect_at("cro_hold", m + 4, ov(0, 0, 0, 2'b00, 0, 4'b0000));
        expect_at("cro_mode1", m + 5, V_IDLE);
        step(8);
        n = cyc;
        sw_mode = 1'b1;
        expect_at("swm_mode0", n + 5, ov(0, 0, 0, 2'b00, 0, 4'b0000));
        step(8);
        sw_mode = 1'b0;
        step(8);

        // reset in the middle of wired ownership
        n = cyc;
        wired_btn[0] = 1'b1;
        expect_at("pre_rst_grant", n + 5, ov(0, 0, 1, 2'b01, 0, 4'b0001));
        step(8);
        rst_n = 1'b0;
        m = cyc;
        expect_at("pre_rst_hold", m, ov(0, 0, 1, 2'b01, 0, 4'b0001));
        expect_at("mid_rst", m + 1, V_IDLE);
        step(1);
        rst_n = 1'b1;
        expect_at("rst_redb", m + 5, V_IDLE);
        expect_at("rst_regrant", m + 6, ov(0, 0, 1, 2'b01, 0, 4'b0001));
        step(10);
        wired_btn[0] = 1'b0;
        step(25);

        check_eq("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
